// File: rtl/ranging_sequencer.sv
// Ultrasonic ranging controller: fires a burst, blanks ring-down, times the echo and
// averages 2^AVG_LOG2 pings into one reported time-of-flight count.
module ranging_sequencer #(
  parameter int unsigned BLANK_CYC   = 100000,
  parameter int unsigned TIMEOUT_CYC = 3000000,
  parameter int unsigned GAP_CYC     = 500000,
  parameter int unsigned REPEAT_CYC  = 10000000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TOF_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_mode,
  input  logic             abort,
  input  logic             echo,
  input  logic             burst_done,
  output logic             burst_req,
  output logic [TOF_W-1:0] tof,
  output logic             tof_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned AccW = TOF_W + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0]  SetLen     = CntW'(1 << AVG_LOG2);
  localparam logic [TOF_W-1:0] BlankVal   = TOF_W'(BLANK_CYC);
  localparam logic [TOF_W-1:0] TimeoutVal = TOF_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StBlank,
    StListen,
    StReport,
    StGap
  } state_t;

  state_t           state_q;
  logic             start_q;
  logic [TOF_W-1:0] tof_cnt_q;
  logic [AccW-1:0]  acc_q;
  logic [CntW-1:0]  samp_q;
  logic [31:0]      rep_q;
  logic [31:0]      gap_q;
  // Set finished (reported or abandoned): GAP then returns to IDLE instead of firing.
  logic             set_end_q;

  logic             start_edge;
  logic             trigger;
  logic [TOF_W-1:0] tof_cnt_inc;
  logic [AccW-1:0]  acc_sum;
  logic [CntW-1:0]  samp_inc;
  logic             set_full;
  logic [TOF_W-1:0] avg;

  always_comb begin
    start_edge  = start & ~start_q;
    trigger     = start_edge | (auto_mode & (rep_q == REPEAT_CYC - 1));
    tof_cnt_inc = (&tof_cnt_q) ? tof_cnt_q : tof_cnt_q + 1'b1;
    acc_sum     = acc_q + AccW'(tof_cnt_q);
    samp_inc    = samp_q + 1'b1;
    set_full    = (samp_inc == SetLen);
    avg         = TOF_W'(acc_sum >> AVG_LOG2);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      tof_cnt_q <= '0;
      acc_q     <= '0;
      samp_q    <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      set_end_q <= 1'b0;
      burst_req <= 1'b0;
      tof       <= '0;
      tof_valid <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort) begin
      // start_q keeps tracking so a start held through abort is not seen as a new edge.
      state_q   <= StIdle;
      start_q   <= start;
      tof_cnt_q <= '0;
      acc_q     <= '0;
      samp_q    <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      set_end_q <= 1'b0;
      burst_req <= 1'b0;
      tof       <= '0;
      tof_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      start_q   <= start;
      tof_valid <= 1'b0;
      timeout   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q   <= StFire;
            tof_cnt_q <= '0;
            burst_req <= 1'b1;
            rep_q     <= '0;
            set_end_q <= 1'b0;
          end else if (auto_mode) begin
            rep_q <= rep_q + 1'b1;
          end else begin
            rep_q <= '0;
          end
        end
        StFire: begin
          tof_cnt_q <= tof_cnt_inc;
          if (burst_done) begin
            burst_req <= 1'b0;
            state_q   <= (tof_cnt_q >= BlankVal) ? StListen : StBlank;
          end
        end
        StBlank: begin
          tof_cnt_q <= tof_cnt_inc;
          if (tof_cnt_q >= BlankVal) begin
            state_q <= StListen;
          end
        end
        StListen: begin
          tof_cnt_q <= tof_cnt_inc;
          if (echo) begin
            acc_q  <= acc_sum;
            samp_q <= samp_inc;
            gap_q  <= '0;
            if (set_full) begin
              tof       <= avg;
              tof_valid <= 1'b1;
              state_q   <= StReport;
            end else begin
              state_q <= StGap;
            end
          end else if (tof_cnt_q == TimeoutVal) begin
            timeout   <= 1'b1;
            acc_q     <= '0;
            samp_q    <= '0;
            set_end_q <= 1'b1;
            gap_q     <= '0;
            state_q   <= StGap;
          end
        end
        StReport: begin
          acc_q     <= '0;
          samp_q    <= '0;
          set_end_q <= 1'b1;
          gap_q     <= '0;
          state_q   <= StGap;
        end
        StGap: begin
          if (gap_q == GAP_CYC - 1) begin
            if (set_end_q) begin
              state_q <= StIdle;
              rep_q   <= '0;
            end else begin
              state_q   <= StFire;
              tof_cnt_q <= '0;
              burst_req <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ranging_sequencer.sv
// Randomized bench for ranging_sequencer: a responder plays transmitter and echo, a model
// predicts each report/timeout, and a monitor scores them as the DUT presents them.
module tb_ranging_sequencer;

  localparam int BLANK = 10;
  localparam int TMO   = 100;
  localparam int GAP   = 5;
  localparam int REP   = 50;
  localparam int AVG   = 1;
  localparam int W     = 12;
  localparam int NP    = 1 << AVG;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         auto_mode;
  logic         abort;
  logic         echo;
  logic         burst_done;
  logic         burst_req;
  logic [W-1:0] tof;
  logic         tof_valid;
  logic         timeout;
  logic         busy;

  always #5 clk = ~clk;

  ranging_sequencer #(
    .BLANK_CYC  (BLANK),
    .TIMEOUT_CYC(TMO),
    .GAP_CYC    (GAP),
    .REPEAT_CYC (REP),
    .AVG_LOG2   (AVG),
    .TOF_W      (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .auto_mode (auto_mode),
    .abort     (abort),
    .echo      (echo),
    .burst_done(burst_done),
    .burst_req (burst_req),
    .tof       (tof),
    .tof_valid (tof_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  // e/s: echo and stray-echo cycles relative to FIRE entry (-1 = none).
  typedef struct {int d; int e; int s; int prev_gap;} plan_t;
  typedef struct {bit is_to; int value; int offset;} exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fire_cyc = 0;
  int rel = 0;
  int ping_num = 0;
  bit active = 1'b0;
  int model_tof = 0;
  int last_end = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input bit lvl, input int bound, input string name);
    int n = 0;
    while (busy !== lvl && n < bound) begin
      tick();
      n++;
    end
    if (busy !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s: busy stuck at %0b after %0d cycles", name, busy, bound);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference model: derive each ping's outcome from the plan and queue the expected event.
  task automatic plan_set(input int first_gap);
    int sum = 0;
    int prev_e = 0;
    for (int i = 0; i < NP; i++) begin
      plan_t p;
      int l;
      int mode;
      p.d  = $urandom_range(0, 14);
      l    = ((p.d > BLANK) ? p.d : BLANK) + 1;
      mode = $urandom_range(0, 9);
      p.s  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, l - 1)) : -1;
      if (mode < 6)       p.e = $urandom_range(l, TMO);
      else if (mode == 6) p.e = TMO;
      else if (mode == 7) p.e = -1;
      else                p.e = $urandom_range(0, l - 1);
      p.prev_gap = (i == 0) ? first_gap : prev_e + 1 + GAP;
      plan_q.push_back(p);
      if (p.e >= l) begin
        sum += p.e;
        prev_e = p.e;
        if (i == NP - 1) begin
          model_tof = sum >> AVG;
          exp_q.push_back('{is_to: 1'b0, value: model_tof, offset: p.e + 1});
          last_end = p.e + 2 + GAP;
        end
      end else begin
        exp_q.push_back('{is_to: 1'b1, value: model_tof, offset: TMO + 1});
        last_end = TMO + 1 + GAP;
        break;
      end
    end
  endtask

  initial begin : responder
    plan_t p;
    int end_rel;
    int l;
    int prev_fire;
    p = '{d: 0, e: -1, s: -1, prev_gap: -1};
    end_rel = 0;
    prev_fire = 0;
    echo = 1'b0;
    burst_done = 1'b0;
    forever begin
      tick();
      burst_done = 1'b0;
      echo = 1'b0;
      if (active && !busy) active = 1'b0;
      if (!active && burst_req) begin
        active = 1'b1;
        rel = 0;
        ping_num++;
        if (plan_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unplanned_burst: burst_req=1 with no ping planned (cycle %0d)", cyc);
          p = '{d: 0, e: -1, s: -1, prev_gap: -1};
        end else begin
          p = plan_q.pop_front();
        end
        if (p.prev_gap >= 0) check("fire_interval", cyc - prev_fire, p.prev_gap);
        prev_fire = cyc;
        fire_cyc = cyc;
        l = ((p.d > BLANK) ? p.d : BLANK) + 1;
        end_rel = (p.e >= l) ? p.e + 1 : TMO + 1;
      end else if (active) begin
        rel++;
      end
      if (active) begin
        if (rel == p.d) burst_done = 1'b1;
        if (rel == p.e || rel == p.s) echo = 1'b1;
        if (rel >= end_rel) active = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      tick();
      if (tof_valid || timeout) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: tof_valid=%0b timeout=%0b tof=%0d expected none",
                   tof_valid, timeout, tof);
        end else begin
          x = exp_q.pop_front();
          check("event_kind_timeout", int'(timeout), int'(x.is_to));
          check("tof_value", int'(tof), x.value);
          check("event_offset", cyc - fire_cyc, x.offset);
          check("pulse_exclusive", int'(tof_valid & timeout), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int g;
    rst = 1'b1;
    start = 1'b0;
    auto_mode = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    check("reset_burst_req", int'(burst_req), 0);
    check("reset_tof", int'(tof), 0);
    check("reset_tof_valid", int'(tof_valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Manually triggered random sets, with an ignored start edge mid-set.
    for (int s = 0; s < 16; s++) begin
      plan_set(-1);
      pulse_start();
      wait_busy(1'b1, 5, "set_start");
      if (s % 2 == 1) begin
        repeat ($urandom_range(1, 8)) tick();
        pulse_start();
      end
      wait_busy(1'b0, 600, "set_end");
      check("plans_used", plan_q.size(), 0);
      check("events_seen", exp_q.size(), 0);
      repeat ($urandom_range(2, 6)) tick();
    end

    // Auto mode: two sets re-triggered REP cycles after each return to IDLE.
    plan_set(-1);
    g = last_end + REP;
    plan_set(g);
    auto_mode = 1'b1;
    wait_busy(1'b1, REP + 5, "auto_first");
    wait_busy(1'b0, 600, "auto_first_end");
    wait_busy(1'b1, REP + 5, "auto_second");
    wait_busy(1'b0, 600, "auto_second_end");
    auto_mode = 1'b0;
    n = 0;
    repeat (3 * REP) begin
      tick();
      if (busy) n++;
    end
    check("auto_off_no_ping", n, 0);
    check("auto_plans_used", plan_q.size(), 0);
    check("auto_events_seen", exp_q.size(), 0);

    // Abort together with start: no trigger.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      if (busy) n++;
    end
    check("abort_start_no_trigger", n, 0);

    // Abort in LISTEN of the second ping after the first echoed: partial set discarded.
    plan_q.push_back('{d: 2, e: 30, s: -1, prev_gap: -1});
    plan_q.push_back('{d: 2, e: -1, s: -1, prev_gap: 30 + 1 + GAP});
    g = ping_num + 2;
    pulse_start();
    n = 0;
    while (!(active && ping_num == g && rel == 50) && n < 400) begin
      tick();
      n++;
    end
    check("abort_reached_listen", int'(active && ping_num == g && rel == 50), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_tof = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_burst_req", int'(burst_req), 0);
    check("abort_tof", int'(tof), 0);
    repeat (3) tick();
    plan_set(-1);
    pulse_start();
    wait_busy(1'b0, 600, "post_abort_end");
    check("post_abort_events", exp_q.size(), 0);

    // Reset during FIRE.
    plan_q.push_back('{d: 20, e: 40, s: -1, prev_gap: -1});
    pulse_start();
    wait_busy(1'b1, 5, "rst_fire_start");
    tick();
    check("fire_burst_req", int'(burst_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_tof = 0;
    check("rst_fire_burst_req", int'(burst_req), 0);
    check("rst_fire_busy", int'(busy), 0);
    check("rst_fire_tof", int'(tof), 0);
    check("rst_fire_tof_valid", int'(tof_valid), 0);
    check("rst_fire_timeout", int'(timeout), 0);
    repeat (3) tick();
    plan_set(-1);
    pulse_start();
    wait_busy(1'b0, 600, "post_rst_end");
    check("post_rst_events", exp_q.size(), 0);
    check("post_rst_plans", plan_q.size(), 0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
